// File: rtl/sevenseg_scan_display.sv
// Multiplexed seven-segment scan driver for a common-anode display.
// Digits are scanned right to left from digit 0, each held for PRESCALE cycles.
// New data is double-buffered and only takes effect at a frame boundary.
// Optional feature: define SEVENSEG_LZ_BLANK_EN to blank leading zero digits.
module sevenseg_scan_display #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    data_valid,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         disp_reg_q, disp_reg_d;
  logic [DW-1:0]         pend_reg_q, pend_reg_d;
  logic                  pend_flag_q, pend_flag_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  boundary;
  logic [3:0]            nibble;

  // Active-low hex decode, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler and digit index; frame boundary is the last tick of the last digit
  always_comb begin
    tick     = (pcnt_q == PCNT_LAST);
    boundary = tick && (idx_q == IDX_LAST);
    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: pending value latches any time, display swaps only at a boundary
  always_comb begin
    disp_reg_d  = disp_reg_q;
    pend_reg_d  = pend_reg_q;
    pend_flag_d = pend_flag_q;
    if (boundary) begin
      pend_flag_d = 1'b0;
      if (data_valid) begin
        // A strobe on the boundary bypasses the pending slot and supersedes it
        disp_reg_d = data_in;
      end else if (pend_flag_q) begin
        disp_reg_d = pend_reg_q;
      end
    end else if (data_valid) begin
      pend_reg_d  = data_in;
      pend_flag_d = 1'b1;
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_blank;

  // Digit k>0 is blank when it and every higher nibble are zero
  always_comb begin
    lz_blank = '0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lz_blank[k] = ((disp_reg_q >> (4 * k)) == '0);
    end
  end
`endif

  // Registered outputs follow the current index, lagging it by one cycle
  always_comb begin
    nibble       = disp_reg_q[{idx_q, 2'b00} +: 4];
    an_d         = ~(NUM_DIGITS'(1) << idx_q);
    seg_d        = hex2seg(nibble);
    frame_done_d = boundary;
`ifdef SEVENSEG_LZ_BLANK_EN
    if (lz_blank[idx_q]) begin
      seg_d = 7'h7F;
    end
`endif
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      disp_reg_q   <= '0;
      pend_reg_q   <= '0;
      pend_flag_q  <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      disp_reg_q   <= disp_reg_d;
      pend_reg_q   <= pend_reg_d;
      pend_flag_q  <= pend_flag_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_display.sv
// Self-checking bench for sevenseg_scan_display (NUM_DIGITS=4, PRESCALE=4).
// Expected outputs for each frame are pushed to a queue and popped cycle by cycle.
module tb_sevenseg_scan_display;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [15:0]   data_in;
  logic          data_valid;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  typedef struct {
    logic [15:0] d0;
    int          c0;
    logic [15:0] d1;
    int          c1;
    logic [15:0] next;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  sevenseg_scan_display #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .an        (an),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
    logic [15:0] s;
    s = v >> (4 * k);
`ifdef SEVENSEG_LZ_BLANK_EN
    if (k > 0 && s == 16'h0) return 7'h7F;
`endif
    return dec(s[3:0]);
  endfunction

  // Checks one full frame showing `shown`, optionally strobing data at cycles c0/c1.
  // Entered when the next rising edge is the first edge of the frame.
  task automatic run_frame(input string tag, input logic [15:0] shown,
                           input logic [15:0] d0, input int c0,
                           input logic [15:0] d1, input int c1);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      e.an  = ~(4'b0001 << (i / PS));
      e.seg = exp_seg(shown, i / PS);
      e.fd  = (i == FRAME - 1);
      sb.push_back(e);
    end
    for (int i = 0; i < FRAME; i++) begin
      data_valid = 1'b0;
      if (i == c0) begin data_valid = 1'b1; data_in = d0; end
      if (i == c1) begin data_valid = 1'b1; data_in = d1; end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      e = sb.pop_front();
      check($sformatf("%s an cyc%0d", tag, i), 32'(an), 32'(e.an));
      check($sformatf("%s seg cyc%0d", tag, i), 32'(seg), 32'(e.seg));
      check($sformatf("%s frame_done cyc%0d", tag, i), 32'(frame_done), 32'(e.fd));
    end
  endtask

  initial begin
    logic [15:0] shown;
    arst_n     = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;

    // Loads scheduled by cycle within the frame; -1 means no strobe.
    // Cycle 15 strobes land on the frame boundary edge.
    vecs[0] = '{16'h0000, -1, 16'h0000, -1, 16'h0000};
    vecs[1] = '{16'h1234,  5, 16'h0000, -1, 16'h1234};
    vecs[2] = '{16'hAAAA,  2, 16'h00F0,  9, 16'h00F0};
    vecs[3] = '{16'h8888, 15, 16'h0000, -1, 16'h8888};
    vecs[4] = '{16'h5555,  3, 16'h8888, 15, 16'h8888};
    vecs[5] = '{16'h0000, -1, 16'h0000, -1, 16'h8888};
    vecs[6] = '{16'h0070, 14, 16'h0000, -1, 16'h0070};
    vecs[7] = '{16'hFEDC,  0, 16'h0000, -1, 16'hFEDC};
    vecs[8] = '{16'hBA98,  7, 16'h0000, -1, 16'hBA98};
    vecs[9] = '{16'h5670, 11, 16'h0000, -1, 16'h5670};

    repeat (3) @(posedge clk);
    #1;
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'h7F);
    check("reset frame_done", 32'(frame_done), 32'h0);

    @(negedge clk);
    arst_n = 1'b1;

    shown = 16'h0000;
    for (int v = 0; v < 10; v++) begin
      run_frame($sformatf("vec%0d", v), shown, vecs[v].d0, vecs[v].c0, vecs[v].d1, vecs[v].c1);
      shown = vecs[v].next;
    end

    // Mid-scan reset while a pending value is held
    data_valid = 1'b1;
    data_in    = 16'hABCD;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre-reset an digit2", 32'(an), 32'hB);
    #2;
    arst_n = 1'b0;
    #1;
    check("async reset an", 32'(an), 32'hF);
    check("async reset seg", 32'(seg), 32'h7F);
    check("async reset frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    run_frame("post-reset0", 16'h0000, 16'h0, -1, 16'h0, -1);
    run_frame("post-reset1", 16'h0000, 16'h0, -1, 16'h0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
